crypto_key_vault: RTL
=====================

# crypto_key_vault

Parametrised multi-slot key store that replaces the single-register key holder in the crypto datapath. It holds NUM_SLOTS keys of KEY_W bits each. Each slot has a per-slot sticky write-lock and a valid flag. A multi-cycle zeroize sequence clears every slot, lock and valid flag. Reads are registered and qualified by a valid strobe. The block sits between the host configuration interface and the cipher cores' key ports.

## Interface
- KEY_W, 16, key width in bits
- NUM_SLOTS, 8, number of key slots (≥2)
- SLOT_AW, $clog2(NUM_SLOTS), slot index width
- clk  in  1  clock; all logic on rising edge
- resetn  in  1  reset, asynchronous, active-low
- wr_en  in  1  write request
- wr_slot  in  SLOT_AW  write slot index
- wr_data  in  KEY_W  key to store
- rd_en  in  1  read request
- rd_slot  in  SLOT_AW  read slot index
- rd_data  out  KEY_W  registered read data
- rd_valid  out  1  one-cycle strobe, rd_data holds a valid key
- lock_en  in  1  lock request for lock_slot
- lock_slot  in  SLOT_AW  slot to lock
- zeroize  in  1  start zeroize sequence (level, sampled when idle)
- busy  out  1  zeroize in progress
- err  out  1  one-cycle strobe on a rejected request

## Operation
- Reset behaviour (resetn low, asynchronous):
  - All slots, lock bits and valid bits clear to 0.
  - rd_data=0, rd_valid=0, busy=0, err=0.
  - The FSM returns to IDLE.
  - Reset mid-zeroize aborts the sequence; storage is fully cleared anyway.
- FSM has two states:
  - IDLE→ZERO when zeroize=1 in IDLE. Zeroize counter zcnt loads 0.
  - ZERO clears slot[zcnt], lock[zcnt] and valid[zcnt] each cycle, then increments zcnt.
  - ZERO→IDLE after slot NUM_SLOTS-1 is cleared.
  - zeroize held high on return to IDLE starts a new sequence.
- busy=1 exactly while the FSM is in ZERO.
- While busy:
  - wr_en, rd_en and lock_en are ignored.
  - No err is raised; rd_valid stays 0.
- Write (IDLE, wr_en=1):
  - lock[wr_slot]=0: slot stores wr_data and valid[wr_slot] is set.
  - lock[wr_slot]=1: slot is unchanged and err pulses the next cycle.
- Lock (IDLE, lock_en=1):
  - Sets lock[lock_slot], including on an empty slot.
  - Sticky; cleared only by zeroize or reset.
- Read (IDLE, rd_en=1):
  - valid[rd_slot]=1: next cycle rd_data=slot value, rd_valid=1.
  - valid[rd_slot]=0: next cycle rd_data=0, rd_valid=0, err=1.
- rd_data holds its value until the next accepted read, rejected read, zeroize start or reset. rd_data clears to 0 on entering ZERO.
- Out-of-range indices (≥NUM_SLOTS, non-power-of-2 depth): the request is rejected and err pulses.
- Simultaneous events in the same IDLE cycle:
  - zeroize overrides wr/rd/lock; these are dropped with no err.
  - Write and lock to the same slot: the write is checked against the pre-cycle lock state, so it lands, then the lock sets.
  - Read and write to the same slot: the read returns the pre-write contents, or err if the slot was empty.
  - A write rejection and a read rejection in the same cycle produce a single err pulse.

## Timing
- Write/lock visible to requests in the cycle after acceptance.
- Read latency 1 cycle (rd_en at edge N → rd_data/rd_valid valid after edge N+1).
- err asserted for exactly one cycle, registered, 1 cycle after the offending request.
- Zeroize duration: busy high for exactly NUM_SLOTS cycles, starting the cycle after zeroize is sampled.
- No combinational path from inputs to outputs.

## Test plan
- Reset then read each slot 0..7 → rd_valid=0, rd_data=0, err=1 each read; busy=0.
- Write 16'hA5A5 to slot 3, read slot 3 next cycle → rd_data=16'hA5A5, rd_valid=1 one cycle later, err=0.
- Lock slot 3, then write 16'h1234 to slot 3 → err pulse 1 cycle; read slot 3 still returns 16'hA5A5.
- Same cycle: wr slot 5=16'h00FF and rd slot 5 on an empty slot → err=1, rd_valid=0; the following read returns 16'h00FF.
- Fill all slots, lock 0 and 7, pulse zeroize:
  - busy high exactly 8 cycles; wr/rd during busy are ignored with no err.
  - Afterwards every read gives err=1.
  - Writing 16'hBEEF to slot 0 succeeds.
- Assert resetn low on the 4th zeroize cycle → outputs 0 immediately, busy=0; after release, all slots read empty and none are locked.

Source files
------------

// File: rtl/crypto_key_vault.sv
// crypto_key_vault: multi-slot key store with sticky per-slot write locks,
// per-slot valid flags, registered reads and a multi-cycle zeroize sequence.
module crypto_key_vault #(
  parameter int unsigned KEY_W     = 16,
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned SLOT_AW   = $clog2(NUM_SLOTS)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               wr_en,
  input  logic [SLOT_AW-1:0] wr_slot,
  input  logic [KEY_W-1:0]   wr_data,
  input  logic               rd_en,
  input  logic [SLOT_AW-1:0] rd_slot,
  output logic [KEY_W-1:0]   rd_data,
  output logic               rd_valid,
  input  logic               lock_en,
  input  logic [SLOT_AW-1:0] lock_slot,
  input  logic               zeroize,
  output logic               busy,
  output logic               err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ZERO = 1'b1;

  localparam logic [SLOT_AW-1:0] LAST_SLOT = SLOT_AW'(NUM_SLOTS - 1);

  logic [0:0]         state_q, state_d;
  logic [SLOT_AW-1:0] zcnt_q, zcnt_d;

  logic [KEY_W-1:0]     slot_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] lock_q;
  logic [NUM_SLOTS-1:0] valid_q;

  logic act_c;
  logic zero_start_c;
  logic wr_in_range_c, rd_in_range_c, lock_in_range_c;
  logic wr_ok_c, wr_rej_c;
  logic rd_ok_c, rd_rej_c;
  logic lock_ok_c, lock_rej_c;

  // Index is usable only when it addresses an existing slot.
  function automatic logic in_range(input logic [SLOT_AW-1:0] idx);
    return (32'(idx) < NUM_SLOTS);
  endfunction

  // Request qualification; zeroize in IDLE silently drops every other request.
  always_comb begin
    zero_start_c    = (state_q == IDLE) && zeroize;
    act_c           = (state_q == IDLE) && !zeroize;
    wr_in_range_c   = in_range(wr_slot);
    rd_in_range_c   = in_range(rd_slot);
    lock_in_range_c = in_range(lock_slot);
    wr_ok_c    = act_c && wr_en && wr_in_range_c && !lock_q[wr_slot];
    wr_rej_c   = act_c && wr_en && !(wr_in_range_c && !lock_q[wr_slot]);
    rd_ok_c    = act_c && rd_en && rd_in_range_c && valid_q[rd_slot];
    rd_rej_c   = act_c && rd_en && !(rd_in_range_c && valid_q[rd_slot]);
    lock_ok_c  = act_c && lock_en && lock_in_range_c;
    lock_rej_c = act_c && lock_en && !lock_in_range_c;
  end

  // FSM state and zeroize counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      zcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      zcnt_q  <= zcnt_d;
    end
  end

  // Next-state logic: walk zcnt across every slot, then return to IDLE.
  always_comb begin
    state_d = state_q;
    zcnt_d  = zcnt_q;
    case (state_q)
      IDLE: begin
        if (zeroize) begin
          state_d = ZERO;
          zcnt_d  = '0;
        end
      end
      ZERO: begin
        zcnt_d = zcnt_q + SLOT_AW'(1);
        if (zcnt_q == LAST_SLOT) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        zcnt_d  = '0;
      end
    endcase
  end

  // Key storage, lock and valid flags; write checks the pre-cycle lock state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot_q  <= '{default: '0};
      lock_q  <= '0;
      valid_q <= '0;
    end else if (state_q == ZERO) begin
      slot_q[zcnt_q]  <= '0;
      lock_q[zcnt_q]  <= 1'b0;
      valid_q[zcnt_q] <= 1'b0;
    end else begin
      if (wr_ok_c) begin
        slot_q[wr_slot]  <= wr_data;
        valid_q[wr_slot] <= 1'b1;
      end
      if (lock_ok_c) begin
        lock_q[lock_slot] <= 1'b1;
      end
    end
  end

  // Registered read port and single merged error strobe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= rd_ok_c;
      err      <= wr_rej_c || rd_rej_c || lock_rej_c;
      if (zero_start_c || rd_rej_c) begin
        rd_data <= '0;
      end else if (rd_ok_c) begin
        rd_data <= slot_q[rd_slot];
      end
    end
  end

  assign busy = (state_q == ZERO);

endmodule
